uart_autobaud_rx: RTL and testbench

Parametrised auto-baud UART receiver for the iCE designs. It measures the start bit of a calibration character to learn the bit period, then receives frames of configurable width and parity. Frames are delivered over a valid/ready handshake with error flags. It sits between the RX pin resynchroniser and the user logic, replacing fixed-width auto-baud receive paths.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_autobaud_rx.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_autobaud_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the auto-baud UART receiver.
// The package holds the FSM state encoding, the parity mode codes and the frame-length helper.
package uart_pkg;

    typedef enum logic [3:0] {
        UNLOCKED,
        MEASURE,
        SKIP,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAITHI
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Returns the number of line bits after the start bit and before the stop bit.
    function automatic int frame_bits(input int data_w, input int parity);
        return data_w + ((parity != PAR_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that times bit samples. The expire pulse comes period cycles after a full
// load, or period/2 cycles after a half load. It never stalls; the owner reloads or stops it.
module uart_bit_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [CNT_W-1:0] period,
    input  logic             load_full,
    input  logic             load_half,
    input  logic             run,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load_full) begin
            cnt <= period - ONE;
        end else if (load_half) begin
            cnt <= (period >> 1) - ONE;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/uart_autobaud_rx.sv
// Auto-baud UART receiver: learns the bit period from a calibration start bit, then receives frames.
// A frame appears one cycle after its stop sample; if the one-deep output is still held, it is dropped.
module uart_autobaud_rx
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int PARITY  = PAR_NONE,
    parameter int MIN_BIT = 8
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_rx,
    input  logic              i_relock,
    output logic              o_locked,
    output logic [CNT_W-1:0]  o_bit_period,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun
);

    localparam int               NB        = frame_bits(DATA_W, PARITY);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_BIT);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(NB);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t state;
    state_t state_nx;

    logic              rx_q;
    logic              fall;
    logic              rise;
    logic [CNT_W-1:0]  meas_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  timer_period;
    logic [DATA_W-1:0] shreg;
    logic              par_err;
    logic              par_calc;

    logic meas_start;
    logic meas_inc;
    logic latch_period;
    logic bits_clr;
    logic bits_inc;
    logic do_shift;
    logic do_parity;
    logic do_stop;
    logic load_full;
    logic load_half;
    logic timer_run;
    logic expire;

    assign fall     = rx_q & ~i_rx;
    assign rise     = ~rx_q & i_rx;
    assign par_calc = ^{shreg, i_rx};

    // The SKIP timer is first loaded while the period register is still being latched, so it takes
    // the fresh measurement minus one: the calibration frame then ends one cycle early, and a
    // start bit that follows back to back still shows its falling edge in IDLE.
    assign timer_period = (state == MEASURE) ? (meas_cnt - ONE) : o_bit_period;

    uart_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (i_clk),
        .nrst     (i_nrst),
        .period   (timer_period),
        .load_full(load_full),
        .load_half(load_half),
        .run      (timer_run),
        .expire   (expire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        meas_start   = 1'b0;
        meas_inc     = 1'b0;
        latch_period = 1'b0;
        bits_clr     = 1'b0;
        bits_inc     = 1'b0;
        do_shift     = 1'b0;
        do_parity    = 1'b0;
        do_stop      = 1'b0;
        load_full    = 1'b0;
        load_half    = 1'b0;
        timer_run    = 1'b0;

        case (state)
            UNLOCKED: begin
                if (fall) begin
                    meas_start = 1'b1;
                    state_nx   = MEASURE;
                end
            end
            MEASURE: begin
                if (meas_cnt == CNT_MAX) begin
                    state_nx = UNLOCKED;
                end else if (rise) begin
                    if (meas_cnt >= MIN_CNT) begin
                        latch_period = 1'b1;
                        bits_clr     = 1'b1;
                        load_full    = 1'b1;
                        state_nx     = SKIP;
                    end else begin
                        state_nx = UNLOCKED;
                    end
                end else begin
                    meas_inc = 1'b1;
                end
            end
            SKIP: begin
                timer_run = 1'b1;
                if (expire) begin
                    if (bit_cnt == SKIP_LAST) begin
                        state_nx = IDLE;
                    end else begin
                        bits_inc  = 1'b1;
                        load_full = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (fall) begin
                    load_half = 1'b1;
                    state_nx  = START;
                end
            end
            START: begin
                timer_run = 1'b1;
                if (expire) begin
                    if (i_rx) begin
                        state_nx = IDLE;
                    end else begin
                        bits_clr  = 1'b1;
                        load_full = 1'b1;
                        state_nx  = DATA;
                    end
                end
            end
            DATA: begin
                timer_run = 1'b1;
                if (expire) begin
                    do_shift  = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            state_nx = uart_pkg::PARITY;
                        end else begin
                            state_nx = STOP;
                        end
                    end else begin
                        bits_inc = 1'b1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                timer_run = 1'b1;
                if (expire) begin
                    do_parity = 1'b1;
                    load_full = 1'b1;
                    state_nx  = STOP;
                end
            end
            STOP: begin
                timer_run = 1'b1;
                if (expire) begin
                    do_stop  = 1'b1;
                    state_nx = i_rx ? IDLE : WAITHI;
                end
            end
            WAITHI: begin
                if (i_rx) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = UNLOCKED;
            end
        endcase

        // Relock wins over everything, including a stop sample landing in the same cycle.
        if (i_relock) begin
            state_nx     = UNLOCKED;
            meas_start   = 1'b0;
            meas_inc     = 1'b0;
            latch_period = 1'b0;
            bits_clr     = 1'b0;
            bits_inc     = 1'b0;
            do_shift     = 1'b0;
            do_parity    = 1'b0;
            do_stop      = 1'b0;
            load_full    = 1'b0;
            load_half    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            rx_q         <= 1'b1;
            meas_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            o_locked     <= 1'b0;
            o_bit_period <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            rx_q <= i_rx;

            if (meas_start) begin
                meas_cnt <= ONE;
            end else if (meas_inc) begin
                meas_cnt <= meas_cnt + ONE;
            end

            if (i_relock) begin
                o_locked <= 1'b0;
            end else if (latch_period) begin
                o_locked     <= 1'b1;
                o_bit_period <= meas_cnt;
            end

            if (bits_clr) begin
                bit_cnt <= '0;
            end else if (bits_inc) begin
                bit_cnt <= bit_cnt + ONE;
            end

            if (do_shift) begin
                shreg <= {i_rx, shreg[DATA_W-1:1]};
            end

            if (do_parity) begin
                par_err <= (PARITY == PAR_EVEN) ? par_calc : ~par_calc;
            end

            if (do_stop && (!o_valid || i_ready)) begin
                o_valid      <= 1'b1;
                o_data       <= shreg;
                o_parity_err <= (PARITY != PAR_NONE) && par_err;
                o_frame_err  <= ~i_rx;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (do_stop && o_valid && !i_ready) begin
                o_overrun <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_rx.sv
// Scoreboard bench: directed frames into a no-parity and an even-parity receiver,
// with expected frames queued at stimulus time and popped by per-instance monitors.
module tb_uart_autobaud_rx;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        rx0, rx1;
    logic        relock0, relock1;
    logic        rdy0, rdy1;
    logic        locked0, locked1;
    logic [15:0] period0, period1;
    logic        v0, v1;
    logic [7:0]  d0, d1;
    logic        pe0, pe1, fe0, fe1, ov0, ov1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_autobaud_rx #(.DATA_W(8), .CNT_W(16), .PARITY(0), .MIN_BIT(8)) dut0 (
        .i_clk(clk), .i_nrst(nrst), .i_rx(rx0), .i_relock(relock0),
        .o_locked(locked0), .o_bit_period(period0), .o_valid(v0), .i_ready(rdy0),
        .o_data(d0), .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0)
    );

    uart_autobaud_rx #(.DATA_W(8), .CNT_W(16), .PARITY(1), .MIN_BIT(8)) dut1 (
        .i_clk(clk), .i_nrst(nrst), .i_rx(rx1), .i_relock(relock1),
        .o_locked(locked1), .o_bit_period(period1), .o_valid(v1), .i_ready(rdy1),
        .o_data(d1), .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int dut, input logic v);
        if (dut == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic idle(input int dut, input int n);
        drive(dut, 1'b1);
        repeat (n) tick();
    endtask

    // Start bit, nb payload bits LSB first, then the stop level. With hit_ready, i_ready of the
    // first instance is high only for the clock edge on which the stop bit is sampled.
    task automatic send_frame(input int dut, input logic [8:0] bits, input int nb, input int per,
                              input logic stop, input bit hit_ready);
        drive(dut, 1'b0);
        repeat (per) tick();
        for (int i = 0; i < nb; i++) begin
            drive(dut, bits[i]);
            repeat (per) tick();
        end
        drive(dut, stop);
        for (int j = 0; j < per; j++) begin
            if (hit_ready) rdy0 = (j == per / 2);
            tick();
        end
    endtask

    task automatic expect0(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe;
        q0.push_back(e);
    endtask

    task automatic expect1(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d; e.perr = pe; e.ferr = fe;
        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (nrst && v0 && rdy0) begin
            if (q0.size() == 0) begin
                check("unexpected_frame0", {24'h0, d0}, 32'hFFFF_FFFF);
            end else begin
                e0 = q0.pop_front();
                check("data0", {24'h0, d0}, {24'h0, e0.data});
                check("perr0", {31'h0, pe0}, {31'h0, e0.perr});
                check("ferr0", {31'h0, fe0}, {31'h0, e0.ferr});
            end
        end
    end

    always @(negedge clk) begin
        if (nrst && v1 && rdy1) begin
            if (q1.size() == 0) begin
                check("unexpected_frame1", {24'h0, d1}, 32'hFFFF_FFFF);
            end else begin
                e1 = q1.pop_front();
                check("data1", {24'h0, d1}, {24'h0, e1.data});
                check("perr1", {31'h0, pe1}, {31'h0, e1.perr});
                check("ferr1", {31'h0, fe1}, {31'h0, e1.ferr});
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 100000 cycles, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
        relock0 = 1'b0; relock1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (3) tick();
        check("rst_locked",  {31'h0, locked0}, 32'h0);
        check("rst_period",  {16'h0, period0}, 32'h0);
        check("rst_valid",   {31'h0, v0},      32'h0);
        check("rst_data",    {24'h0, d0},      32'h0);
        check("rst_perr",    {31'h0, pe0},     32'h0);
        check("rst_ferr",    {31'h0, fe0},     32'h0);
        check("rst_overrun", {31'h0, ov0},     32'h0);
        nrst = 1'b1;
        idle(0, 10);

        // Glitch while unlocked.
        rx0 = 1'b0;
        repeat (3) tick();
        idle(0, 20);
        check("glitch_locked", {31'h0, locked0}, 32'h0);

        // Calibrate at 104 clocks per bit, then receive 0xA3.
        send_frame(0, 9'h055, 8, 104, 1'b1, 1'b0);
        idle(0, 104);
        check("lock_locked", {31'h0, locked0}, 32'h1);
        check("lock_period", {16'h0, period0}, 32'd104);
        check("cal_no_valid", {31'h0, v0}, 32'h0);
        expect0(8'hA3, 1'b0, 1'b0);
        send_frame(0, 9'h0A3, 8, 104, 1'b1, 1'b0);
        idle(0, 104);
        check("a3_delivered", q0.size(), 32'h0);

        // False start: low for less than half a bit.
        rx0 = 1'b0;
        repeat (20) tick();
        idle(0, 300);
        check("false_start_valid", {31'h0, v0}, 32'h0);

        // Overrun: two frames with the consumer stalled.
        rdy0 = 1'b0;
        expect0(8'h11, 1'b0, 1'b0);
        send_frame(0, 9'h011, 8, 104, 1'b1, 1'b0);
        idle(0, 104);
        send_frame(0, 9'h022, 8, 104, 1'b1, 1'b0);
        idle(0, 104);
        check("ovr_valid", {31'h0, v0},  32'h1);
        check("ovr_data",  {24'h0, d0},  32'h11);
        check("ovr_flag",  {31'h0, ov0}, 32'h1);
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        check("ovr_cleared", {31'h0, ov0}, 32'h0);
        check("ovr_valid_low", {31'h0, v0}, 32'h0);

        // Handshake on the very cycle of the next stop sample.
        expect0(8'h5A, 1'b0, 1'b0);
        expect0(8'hC3, 1'b0, 1'b0);
        send_frame(0, 9'h05A, 8, 104, 1'b1, 1'b0);
        idle(0, 104);
        send_frame(0, 9'h0C3, 8, 104, 1'b1, 1'b1);
        idle(0, 104);
        check("sim_overrun", {31'h0, ov0}, 32'h0);
        check("sim_valid",   {31'h0, v0},  32'h1);
        check("sim_data",    {24'h0, d0},  32'hC3);
        rdy0 = 1'b1;
        repeat (2) tick();
        check("sim_drained", q0.size(), 32'h0);

        // Stop bit low, line held low well past the frame.
        expect0(8'h81, 1'b0, 1'b1);
        send_frame(0, 9'h081, 8, 104, 1'b0, 1'b0);
        rx0 = 1'b0;
        repeat (208) tick();
        idle(0, 208);
        check("ferr_drained", q0.size(), 32'h0);

        // Relock and calibrate at 52 clocks per bit.
        relock0 = 1'b1;
        tick();
        relock0 = 1'b0;
        check("relock_locked", {31'h0, locked0}, 32'h0);
        check("relock_period_held", {16'h0, period0}, 32'd104);
        send_frame(0, 9'h055, 8, 52, 1'b1, 1'b0);
        idle(0, 52);
        check("relock_locked2", {31'h0, locked0}, 32'h1);
        check("relock_period2", {16'h0, period0}, 32'd52);
        expect0(8'h3C, 1'b0, 1'b0);
        send_frame(0, 9'h03C, 8, 52, 1'b1, 1'b0);
        idle(0, 52);

        // Even parity instance at 16 clocks per bit.
        send_frame(1, 9'h055, 9, 16, 1'b1, 1'b0);
        idle(1, 16);
        check("par_locked", {31'h0, locked1}, 32'h1);
        check("par_period", {16'h0, period1}, 32'd16);
        expect1(8'h07, 1'b1, 1'b0);
        send_frame(1, 9'h007, 9, 16, 1'b1, 1'b0);
        idle(1, 16);
        expect1(8'h07, 1'b0, 1'b0);
        send_frame(1, 9'h107, 9, 16, 1'b1, 1'b0);
        idle(1, 32);

        check("end_queue0", q0.size(), 32'h0);
        check("end_queue1", q1.size(), 32'h0);
        check("end_overrun1", {31'h0, ov1}, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
